uart_txrx: RTL and testbench

- Full-duplex 8N1 UART: one transmit engine and one receive engine sharing one clock and one reset.
- Sits between a byte-wide parallel interface (valid-pulse handshake) and the serial pins.
- Baud rate is set by a static clocks-per-bit divider. No FIFOs and no parity.
- Default configuration is a 10 MHz clock at 115200 baud (87 clocks/bit).

---
 rtl/uart_txrx_pkg.sv | 17 +
 rtl/uart_txrx_rx.sv | 111 +++++++++++
 rtl/uart_txrx_tx.sv | 120 ++++++++++++
 rtl/uart_txrx.sv | 40 ++++
 tb/tb_uart_txrx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_txrx_pkg.sv
// uart_txrx shared types and constants.
// Common FSM state encoding and 8N1 frame levels.
package uart_txrx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_txrx_rx.sv
// uart_txrx receive engine.
// Synchronises the line and samples each bit at its midpoint.
module uart_txrx_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);
  import uart_txrx_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  logic            r_meta, r_sync;
  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [2:0]      r_idx, w_idx_nx;
  logic [7:0]      r_byte, w_byte_nx;
  logic            r_dv, w_dv_nx;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_Rx_Serial;
      r_sync <= r_meta;
    end
  end

  // State, counter and received-byte registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_dv    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_byte  <= w_byte_nx;
      r_dv    <= w_dv_nx;
    end
  end

  // Next-state logic; start is re-checked mid-bit to reject glitches.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_byte_nx  = r_byte;
    w_dv_nx    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        w_idx_nx = '0;
        if (r_sync == START_LEVEL) begin
          w_state_nx = START;
        end
      end
      START: begin
        if (r_cnt == HALF) begin
          w_cnt_nx   = '0;
          w_state_nx = (r_sync == START_LEVEL) ? DATA : IDLE;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nx         = '0;
          w_byte_nx[r_idx] = r_sync;
          if (r_idx == 3'(DATA_BITS - 1)) begin
            w_idx_nx   = '0;
            w_state_nx = STOP;
          end else begin
            w_idx_nx = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nx   = '0;
          w_dv_nx    = (r_sync == STOP_LEVEL);
          w_state_nx = CLEANUP;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      CLEANUP: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign o_Rx_DV   = r_dv;
  assign o_Rx_Byte = r_byte;

endmodule

// File: rtl/uart_txrx_tx.sv
// uart_txrx transmit engine.
// Serialises a latched byte as one 8N1 frame.
module uart_txrx_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);
  import uart_txrx_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [2:0]      r_idx, w_idx_nx;
  logic [2:0]      w_idx_inc;
  logic [7:0]      r_byte, w_byte_nx;
  logic            r_ser, w_ser_nx;
  logic            r_act, w_act_nx;
  logic            r_done, w_done_nx;

  assign w_idx_inc = r_idx + 3'd1;

  // State, counter and registered line outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_ser   <= STOP_LEVEL;
      r_act   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_byte  <= w_byte_nx;
      r_ser   <= w_ser_nx;
      r_act   <= w_act_nx;
      r_done  <= w_done_nx;
    end
  end

  // Next-state logic; the line level is computed one cycle ahead.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_byte_nx  = r_byte;
    w_ser_nx   = r_ser;
    w_act_nx   = r_act;
    w_done_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ser_nx = STOP_LEVEL;
        w_act_nx = 1'b0;
        w_cnt_nx = '0;
        w_idx_nx = '0;
        if (i_Tx_DV) begin
          w_byte_nx  = i_Tx_Byte;
          w_act_nx   = 1'b1;
          w_ser_nx   = START_LEVEL;
          w_state_nx = START;
        end
      end
      START: begin
        if (r_cnt == LAST) begin
          w_cnt_nx   = '0;
          w_ser_nx   = r_byte[0];
          w_state_nx = DATA;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nx = '0;
          if (r_idx == 3'(DATA_BITS - 1)) begin
            w_idx_nx   = '0;
            w_ser_nx   = STOP_LEVEL;
            w_state_nx = STOP;
          end else begin
            w_idx_nx = w_idx_inc;
            w_ser_nx = r_byte[w_idx_inc];
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nx   = '0;
          w_act_nx   = 1'b0;
          w_done_nx  = 1'b1;
          w_state_nx = CLEANUP;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      CLEANUP: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign o_Tx_Serial = r_ser;
  assign o_Tx_Active = r_act;
  assign o_Tx_Done   = r_done;

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx top: full-duplex 8N1 UART.
// Independent TX and RX engines on a shared clock and reset.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  uart_txrx_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Tx_DV    (i_Tx_DV),
    .i_Tx_Byte  (i_Tx_Byte),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Done  (o_Tx_Done)
  );

  uart_txrx_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Rx_DV    (o_Rx_DV),
    .o_Rx_Byte  (o_Rx_Byte)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// uart_txrx testbench.
// Table-driven frames plus glitch, busy and reset sequences.
module tb_uart_txrx;

  localparam int C = 87;

  logic       clk;
  logic       rst_n;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;

  uart_txrx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Rx_DV    (o_Rx_DV),
    .o_Rx_Byte  (o_Rx_Byte),
    .i_Tx_DV    (i_Tx_DV),
    .i_Tx_Byte  (i_Tx_Byte),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Done  (o_Tx_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic       stop;
    int         bitc;
    int         startc;
  } vec_t;

  vec_t vecs[5];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  logic [7:0] rx_got[64];
  int rx_dv_cnt = 0;
  int tx_done_cnt = 0;
  int rx_rd = 0;

  // Monitor: capture every RX valid pulse and count TX done pulses.
  always @(negedge clk) begin
    if (o_Rx_DV === 1'b1) begin
      rx_got[6'(rx_dv_cnt)] = o_Rx_Byte;
      rx_dv_cnt++;
    end
    if (o_Tx_Done === 1'b1) tx_done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rx_hold(input logic lvl, input int n);
    i_Rx_Serial = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop,
                          input int bitc, input int startc);
    if (stop) rx_exp.push_back(b);
    rx_hold(1'b0, startc);
    for (int k = 0; k < 8; k++) rx_hold(b[k], bitc);
    rx_hold(stop, bitc);
    i_Rx_Serial = 1'b1;
  endtask

  task automatic rx_score(input logic [7:0] exp_byte);
    @(negedge clk);
    chk("rx_byte_after_stop", 32'(o_Rx_Byte), 32'(exp_byte));
    rx_hold(1'b1, 2 * C);
    chk("rx_dv_count", rx_dv_cnt - rx_rd, rx_exp.size());
    while (rx_rd < rx_dv_cnt && rx_exp.size() > 0) begin
      chk("rx_dv_byte", 32'(rx_got[6'(rx_rd)]), 32'(rx_exp.pop_front()));
      rx_rd++;
    end
    rx_rd = rx_dv_cnt;
    rx_exp.delete();
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit inject);
    int e_ser, e_act, e_done;
    logic exp_s;
    logic [7:0] dec;
    e_ser = 0;
    e_act = 0;
    e_done = 0;
    dec = 8'h00;
    @(posedge clk);
    #1;
    i_Tx_DV = 1'b1;
    i_Tx_Byte = b;
    tx_exp.push_back(b);
    @(posedge clk);
    #1;
    i_Tx_DV = 1'b0;
    i_Tx_Byte = ~b;
    for (int j = 0; j < 10 * C + 2; j++) begin
      @(negedge clk);
      if (j < C) exp_s = 1'b0;
      else if (j < 9 * C) exp_s = b[3'(j / C - 1)];
      else exp_s = 1'b1;
      if (o_Tx_Serial !== exp_s) e_ser++;
      if (o_Tx_Active !== (j < 10 * C)) e_act++;
      if (o_Tx_Done !== (j == 10 * C)) e_done++;
      if (j >= C && j < 9 * C && (j % C) == C / 2)
        dec[3'(j / C - 1)] = o_Tx_Serial;
      if (inject && j == 300) begin
        i_Tx_DV = 1'b1;
        i_Tx_Byte = 8'h12;
      end
      if (inject && j == 301) i_Tx_DV = 1'b0;
    end
    chk("tx_serial_bad_cycles", e_ser, 0);
    chk("tx_active_bad_cycles", e_act, 0);
    chk("tx_done_bad_cycles", e_done, 0);
    chk("tx_decoded_byte", 32'(dec), 32'(tx_exp.pop_front()));
  endtask

  initial begin
    int dv0, dn0;
    logic [7:0] rxb;

    vecs[0] = '{8'hAB, 8'h3F, 1'b1, 86, 96};
    vecs[1] = '{8'h00, 8'h55, 1'b1, 87, 87};
    vecs[2] = '{8'hFF, 8'hA5, 1'b0, 87, 87};
    vecs[3] = '{8'h5A, 8'h5A, 1'b1, 87, 87};
    vecs[4] = '{8'h81, 8'h01, 1'b1, 88, 88};

    rst_n = 1'b0;
    i_Rx_Serial = 1'b1;
    i_Tx_DV = 1'b0;
    i_Tx_Byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_serial", 32'(o_Tx_Serial), 1);
    chk("rst_tx_active", 32'(o_Tx_Active), 0);
    chk("rst_tx_done", 32'(o_Tx_Done), 0);
    chk("rst_rx_dv", 32'(o_Rx_DV), 0);
    chk("rst_rx_byte", 32'(o_Rx_Byte), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      fork
        tx_frame(vecs[v].tx, 1'b0);
        rx_frame(vecs[v].rx, vecs[v].stop, vecs[v].bitc, vecs[v].startc);
      join
      rx_score(vecs[v].rx);
    end

    dn0 = tx_done_cnt;
    tx_frame(8'hAB, 1'b1);
    repeat (C) @(posedge clk);
    #1;
    chk("tx_busy_done_count", tx_done_cnt - dn0, 1);
    chk("tx_busy_idle_after", 32'(o_Tx_Active), 0);

    rx_hold(1'b0, 20);
    rx_hold(1'b1, 3 * C);
    rx_score(vecs[4].rx);
    rx_frame(8'h55, 1'b1, C, C);
    rx_score(8'h55);

    dv0 = rx_dv_cnt;
    dn0 = tx_done_cnt;
    rxb = 8'h96;
    @(posedge clk);
    #1;
    for (int t = 0; t < 5 * C + 43; t++) begin
      i_Rx_Serial = (t < C) ? 1'b0 : rxb[3'(t / C - 1)];
      if (t == C) begin
        i_Tx_DV = 1'b1;
        i_Tx_Byte = 8'hC3;
      end
      if (t == C + 1) i_Tx_DV = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("mid_tx_active", 32'(o_Tx_Active), 1);
    chk("mid_tx_serial_bit3", 32'(o_Tx_Serial), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx_serial", 32'(o_Tx_Serial), 1);
    chk("rst_async_tx_active", 32'(o_Tx_Active), 0);
    i_Rx_Serial = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    chk("rst_abort_no_dv", rx_dv_cnt - dv0, 0);
    chk("rst_abort_no_done", tx_done_cnt - dn0, 0);
    chk("rst_abort_rx_byte", 32'(o_Rx_Byte), 0);
    rx_rd = rx_dv_cnt;
    fork
      tx_frame(8'hC3, 1'b0);
      rx_frame(8'hC3, 1'b1, C, C);
    join
    rx_score(8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
